sevenseg_scan_driver: RTL and testbench
=======================================

# sevenseg_scan_driver

Parametrised, time-multiplexed hex display driver for a bank of `DIGITS` common-anode seven-segment digits sharing one segment bus. It holds a `4*DIGITS`-bit value supplied by a load strobe and scans one digit per refresh slot with one-hot active-low anode enables. Segment decoding is full hex (0–F) with optional leading-zero blanking and per-digit decimal points. It sits between the datapath and the board display pins, replacing per-digit combinational decoders.

## Interface
- `DIGITS`, 4: number of digits, 1..8; digit 0 is least significant.
- `DIV`, 50000: clocks per digit slot, ≥1.
- `LEADING_BLANK`, 1: 1 enables leading-zero suppression; 0 always shows every digit.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load` input 1: samples `value` and `dp_in` into the pending register.
- `value` input 4*DIGITS: nibble i (bits 4i+3:4i) is digit i.
- `dp_in` input DIGITS: bit i=1 lights the decimal point of digit i.
- `seg` output 7: segments {a,b,c,d,e,f,g}, active-low (0 = lit).
- `dp_n` output 1: decimal point, active-low.
- `an_n` output DIGITS: anode enables, active-low, at most one bit low.
- `frame_done` output 1: one-cycle pulse at each frame start.

## Operation
- Registers: prescaler `cnt` (0..DIV-1), scan index `idx` (0..DIGITS-1, width max(1,clog2(DIGITS))), pending {value,dp}, active {value,dp}, registered outputs.
- `tick` = (`cnt`==DIV-1). `cnt` wraps to 0 on `tick`, otherwise increments. DIV=1 gives `tick` every cycle.
- On `tick`: `idx` <= (`idx`==DIGITS-1) ? 0 : `idx`+1.
- Double buffering: on a `tick` that wraps `idx` to 0, active <= pending, and `frame_done` pulses for one cycle. A frame never mixes old and new data.
- `load` in any cycle overwrites pending. Repeated loads within one frame keep only the last. A `load` coincident with the commit tick is not in that commit; it commits at the next frame.
- Decode (active-low abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Blanking: when LEADING_BLANK=1, digit i>0 is blanked if digits DIGITS-1..i of active are all zero. A blanked digit drives `seg`=1111111. Digit 0 is never blanked, so value 0 shows "0". The decimal point is independent of blanking.
- On `tick`, output registers load `an_n` (bit of next `idx` low), `seg`, and `dp_n` = ~dp[next idx], all computed from the post-commit active data.

## Timing
- Reset values: `cnt`=0; `idx`=DIGITS-1; pending=0; active=0; `an_n`=all 1; `seg`=1111111; `dp_n`=1; `frame_done`=0. The display is dark until the first tick.
- The first tick occurs DIV cycles after `rst_n` rises. It selects digit 0, commits pending and pulses `frame_done`.
- Outputs change only on tick edges and hold for exactly DIV cycles.
- Frame period is DIGITS×DIV cycles.
- Load-to-display latency is at most DIGITS×DIV + DIV cycles, and always at a frame boundary.
- DIGITS=1: `an_n` stays 0 after the first tick; every tick commits and pulses `frame_done`.
- `rst_n` asserted mid-frame immediately forces all reset values, including dark outputs, and discards pending data.

## Structure
- Package `seg7_pkg`:
  - the 16 decode constants,
  - `SEG_BLANK`=7'b1111111,
  - a `seg7_t` 7-bit typedef,
  - an index-width function max(1,clog2(n)).
- Sub-module `hex_to_seg7`: combinational nibble→`seg7_t` decoder, instantiated once on the muxed nibble. Reusable elsewhere.

## Test plan
- Reset then idle, DIGITS=4, DIV=4: outputs dark through cycle 3. Cycle 4 edge gives `an_n`=1110, `seg`=0000001, `frame_done` pulse. The anode rotates 1101, 1011, 0111 every 4 cycles.
- `load` `value`=16'h00A5, `dp_in`=4'b0010, LEADING_BLANK=1, mid-frame: old data holds until the wrap. Next frame shows digit 0 = 0100100 with `dp_n`=1; digit 1 = 0001000 with `dp_n`=0; digits 2 and 3 = 1111111.
- LEADING_BLANK=0 with `value`=16'h0000: all four digits show 0000001. With LEADING_BLANK=1, only digit 0 shows 0000001.
- Loads of 16'h1234 and then 16'hBEEF within one frame: only BEEF is displayed (b=1100000, E=0110000, F=0111000). A load exactly on the commit tick is deferred by one frame.
- DIV=1, DIGITS=1: `an_n`=0 from cycle 1, `frame_done` is high every cycle, and a value change appears 1 cycle after commit.
- Assert `rst_n` low mid-slot: outputs go dark asynchronously. After release, the first tick arrives after DIV cycles and displays 0 (pending cleared).

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   - seg7_t      : 7-bit segment pattern {a,b,c,d,e,f,g}, active-low
//   - SEG_0..SEG_F: hex glyphs, SEG_BLANK: all segments dark
//   - idx_width() : index width helper, max(1, clog2(n))
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b0000001;
    localparam seg7_t SEG_1     = 7'b1001111;
    localparam seg7_t SEG_2     = 7'b0010010;
    localparam seg7_t SEG_3     = 7'b0000110;
    localparam seg7_t SEG_4     = 7'b1001100;
    localparam seg7_t SEG_5     = 7'b0100100;
    localparam seg7_t SEG_6     = 7'b0100000;
    localparam seg7_t SEG_7     = 7'b0001111;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0001100;
    localparam seg7_t SEG_A     = 7'b0001000;
    localparam seg7_t SEG_B     = 7'b1100000;
    localparam seg7_t SEG_C     = 7'b0110001;
    localparam seg7_t SEG_D     = 7'b1000010;
    localparam seg7_t SEG_E     = 7'b0110000;
    localparam seg7_t SEG_F     = 7'b0111000;
    localparam seg7_t SEG_BLANK = 7'b1111111;

    // A 1-deep range still needs a 1-bit register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment decoder.
//   nib_i : 4-bit hex digit
//   seg_o : segment pattern {a,b,c,d,e,f,g}, 0 = lit
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg7_t      seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed hex display driver for DIGITS
// common-anode digits on one shared segment bus.
//   clk, rst_n  : clock, async active-low reset
//   load        : capture value/dp_in into the pending buffer
//   value       : nibble i drives digit i (digit 0 least significant)
//   dp_in       : bit i lights decimal point of digit i
//   seg, dp_n   : registered active-low segment / decimal-point drive
//   an_n        : registered one-hot active-low anode enables
//   frame_done  : one-cycle pulse when a new frame (digit 0) starts
module sevenseg_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int DIV           = 50000,
    parameter int LEADING_BLANK = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int IDX_W = idx_width(DIGITS);
    localparam int CNT_W = idx_width(DIV);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_val_q, act_val_q, act_val_d;
    logic [DIGITS-1:0]   pend_dp_q, act_dp_q, act_dp_d;
    seg7_t               seg_q, seg_d, dec_seg;
    logic                dp_n_q;
    logic [DIGITS-1:0]   an_n_q;
    logic                fd_q;

    logic                tick, last, wrap, blank;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   zero_above;

    always_comb begin
        tick  = (cnt_q == CNT_W'(DIV - 1));
        last  = (idx_q == IDX_W'(DIGITS - 1));
        wrap  = tick && last;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = last ? '0 : idx_q + 1'b1;
        // Outputs for the next slot are decoded from post-commit data so
        // the first digit of a frame already shows the new value.
        act_val_d = wrap ? pend_val_q : act_val_q;
        act_dp_d  = wrap ? pend_dp_q  : act_dp_q;
        nib       = act_val_d[4*int'(idx_d) +: 4];
    end

    // zero_above[i]: digits DIGITS-1 down to i are all zero.
    always_comb begin
        zero_above = '0;
        zero_above[DIGITS-1] = (act_val_d[4*DIGITS-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--)
            zero_above[i] = zero_above[i+1] && (act_val_d[4*i +: 4] == 4'd0);
    end

    hex_to_seg7 u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // Digit 0 is never blanked so a zero value still reads "0".
    always_comb begin
        blank = (LEADING_BLANK != 0) && (idx_d != '0) && zero_above[idx_d];
        seg_d = blank ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= IDX_W'(DIGITS - 1);
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            seg_q      <= SEG_BLANK;
            dp_n_q     <= 1'b1;
            an_n_q     <= '1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fd_q  <= wrap;
            // A load on the commit edge lands in pending after the commit
            // has taken the old pending, so it shows one frame later.
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end
            if (tick) begin
                idx_q     <= idx_d;
                act_val_q <= act_val_d;
                act_dp_q  <= act_dp_d;
                seg_q     <= seg_d;
                dp_n_q    <= ~act_dp_d[idx_d];
                an_n_q    <= ~(DIGITS'(1) << idx_d);
            end
        end
    end

    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1;
    logic [3:0]  an0, an1;

    logic        rst2_n = 1'b0;
    logic        load2 = 1'b0;
    logic [3:0]  value2 = '0;
    logic        dp2_in = 1'b0;
    logic [6:0]  seg2;
    logic        dp2, fd2;
    logic        an2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.DIGITS(4), .DIV(4), .LEADING_BLANK(1)) u0 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg0), .dp_n(dp0), .an_n(an0), .frame_done(fd0));

    sevenseg_scan_driver #(.DIGITS(4), .DIV(4), .LEADING_BLANK(0)) u1 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg1), .dp_n(dp1), .an_n(an1), .frame_done(fd1));

    sevenseg_scan_driver #(.DIGITS(1), .DIV(1), .LEADING_BLANK(1)) u2 (
        .clk(clk), .rst_n(rst2_n), .load(load2), .value(value2), .dp_in(dp2_in),
        .seg(seg2), .dp_n(dp2), .an_n(an2), .frame_done(fd2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each step advances one rising edge; sampling/driving on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // ---- reset state ----
        step(1);
        chk("rst_an", an0, 4'b1111);
        chk("rst_seg", seg0, 7'b1111111);
        chk("rst_dp", dp0, 1'b1);
        chk("rst_fd", fd0, 1'b0);

        // ---- first frame, idle (value 0) ----
        rst_n = 1'b1;
        step(3);
        chk("dark_c3_an", an0, 4'b1111);
        chk("dark_c3_seg", seg0, 7'b1111111);
        step(1);  // edge 4
        chk("c4_an", an0, 4'b1110);
        chk("c4_seg", seg0, 7'b0000001);
        chk("c4_fd", fd0, 1'b1);
        chk("c4_seg_lb0", seg1, 7'b0000001);
        step(1);
        chk("c5_fd", fd0, 1'b0);
        chk("c5_an_hold", an0, 4'b1110);
        step(3);  // edge 8
        chk("c8_an", an0, 4'b1101);
        chk("c8_seg_blank", seg0, 7'b1111111);
        chk("c8_seg_lb0", seg1, 7'b0000001);
        step(4);  // edge 12
        chk("c12_an", an0, 4'b1011);
        step(4);  // edge 16
        chk("c16_an", an0, 4'b0111);
        chk("c16_seg_lb0", seg1, 7'b0000001);

        // ---- mid-frame load of 00A5 ----
        step(2);  // edge 18
        load = 1'b1; value = 16'h00A5; dp_in = 4'b0010;
        step(1);  // edge 19 samples load
        load = 1'b0;
        chk("c19_old_hold_an", an0, 4'b0111);
        chk("c19_old_hold_seg", seg0, 7'b1111111);
        step(1);  // edge 20 commit
        chk("c20_an", an0, 4'b1110);
        chk("c20_seg5", seg0, 7'b0100100);
        chk("c20_dp", dp0, 1'b1);
        chk("c20_fd", fd0, 1'b1);
        step(4);  // edge 24
        chk("c24_segA", seg0, 7'b0001000);
        chk("c24_dp", dp0, 1'b0);
        step(4);  // edge 28
        chk("c28_seg_blank", seg0, 7'b1111111);
        chk("c28_seg_lb0", seg1, 7'b0000001);
        chk("c28_dp", dp0, 1'b1);
        step(4);  // edge 32
        chk("c32_seg_blank", seg0, 7'b1111111);

        // ---- two loads in one frame, then a load on the commit edge ----
        load = 1'b1; value = 16'h1234; dp_in = 4'b0000;
        step(1);  // edge 33
        value = 16'hBEEF;
        step(1);  // edge 34
        load = 1'b0;
        step(1);  // edge 35
        load = 1'b1; value = 16'h0007;
        step(1);  // edge 36 commit of BEEF, 0007 deferred
        load = 1'b0;
        chk("c36_segF", seg0, 7'b0111000);
        chk("c36_fd", fd0, 1'b1);
        chk("c36_dp", dp0, 1'b1);
        step(4);
        chk("c40_segE", seg0, 7'b0110000);
        step(4);
        chk("c44_segE", seg0, 7'b0110000);
        step(4);
        chk("c48_segb", seg0, 7'b1100000);
        chk("c48_an", an0, 4'b0111);
        step(4);  // edge 52 commits 0007
        chk("c52_seg7", seg0, 7'b0001111);
        chk("c52_fd", fd0, 1'b1);
        step(4);
        chk("c56_seg_blank", seg0, 7'b1111111);
        chk("c56_seg_lb0", seg1, 7'b0000001);

        // ---- async reset mid-slot discards pending ----
        load = 1'b1; value = 16'h0009;
        step(2);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", an0, 4'b1111);
        chk("arst_seg", seg0, 7'b1111111);
        chk("arst_dp", dp0, 1'b1);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("rel_c3_an", an0, 4'b1111);
        step(1);
        chk("rel_c4_an", an0, 4'b1110);
        chk("rel_c4_seg0", seg0, 7'b0000001);
        chk("rel_c4_fd", fd0, 1'b1);

        // ---- DIGITS=1, DIV=1 ----
        chk("d1_rst_an", an2, 1'b1);
        rst2_n = 1'b1;
        step(1);
        chk("d1_c1_an", an2, 1'b0);
        chk("d1_c1_seg", seg2, 7'b0000001);
        chk("d1_c1_fd", fd2, 1'b1);
        load2 = 1'b1; value2 = 4'h3; dp2_in = 1'b1;
        step(1);  // load on a commit edge
        load2 = 1'b0;
        chk("d1_c2_seg_old", seg2, 7'b0000001);
        chk("d1_c2_fd", fd2, 1'b1);
        step(1);
        chk("d1_c3_seg3", seg2, 7'b0000110);
        chk("d1_c3_dp", dp2, 1'b0);
        chk("d1_c3_an", an2, 1'b0);
        chk("d1_c3_fd", fd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
